// File: rtl/pipe_stage_ctrl_if.sv
// Handshake and stage-control bundle between the producer/consumer side
// (master) and the pipeline valid/enable controller (slave).
interface pipe_stage_ctrl_if #(
    parameter int NUM_STAGES = 4,
    parameter int CNT_W      = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic                  flush;
    logic [NUM_STAGES-1:0] stage_en;
    logic [NUM_STAGES-1:0] stage_clr;
    logic [NUM_STAGES-1:0] stage_valid;
    logic                  busy;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output in_valid, out_ready, flush,
        input  in_ready, out_valid, stage_en, stage_clr, stage_valid, busy, stall_cnt
    );

    modport slave (
        input  in_valid, out_ready, flush,
        output in_ready, out_valid, stage_en, stage_clr, stage_valid, busy, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_ctrl.sv
// Valid/enable controller for a chain of external pipeline data registers.
// Keeps one valid bit per stage, collapses bubbles, passes consumer
// backpressure upstream combinationally, and after a flush holds the
// producer off for a fixed recovery window.
module pipe_stage_ctrl #(
    parameter int NUM_STAGES     = 4,
    parameter int RECOVER_CYCLES = 2,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stage_ctrl_if.slave bus
);

    localparam int RW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam logic [RW-1:0] RLOAD = RW'((RECOVER_CYCLES > 0) ? RECOVER_CYCLES - 1 : 0);

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t                state;
    logic [RW-1:0]         rcnt;
    logic [NUM_STAGES-1:0] v;
    logic [NUM_STAGES-1:0] acc;
    logic [NUM_STAGES-1:0] en;
    logic                  accept;
    logic                  out_vld;
    logic [CNT_W-1:0]      stall;

    // Acceptance chain from the consumer back to stage 0: a stage can take
    // new data if it is empty or its successor can take its current entry.
    always_comb begin
        acc = '0;
        acc[NUM_STAGES-1] = !v[NUM_STAGES-1] | bus.out_ready;
        for (int i = NUM_STAGES - 2; i >= 0; i--) begin
            acc[i] = !v[i] | acc[i+1];
        end
    end

    // Outputs are forced quiet while in reset and during a flush cycle.
    always_comb begin
        en      = (rst && !bus.flush) ? acc : '0;
        accept  = acc[0] & (state == RUN) & !bus.flush & rst;
        out_vld = v[NUM_STAGES-1] & !bus.flush & rst;
    end

    assign bus.stage_en    = en;
    assign bus.stage_clr   = (!rst || bus.flush) ? '1 : '0;
    assign bus.in_ready    = accept;
    assign bus.out_valid   = out_vld;
    assign bus.stage_valid = v;
    assign bus.busy        = (|v) | (state == RECOVER);
    assign bus.stall_cnt   = stall;

    // Valid bits, RUN/RECOVER state machine and the saturating stall counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v     <= '0;
            state <= RUN;
            rcnt  <= '0;
            stall <= '0;
        end else begin
            if (out_vld && !bus.out_ready && (stall != '1)) begin
                stall <= stall + CNT_W'(1);
            end
            if (bus.flush) begin
                v <= '0;
                if (RECOVER_CYCLES == 0) begin
                    state <= RUN;
                end else begin
                    state <= RECOVER;
                    rcnt  <= RLOAD;
                end
            end else begin
                if (en[0]) begin
                    v[0] <= bus.in_valid & accept;
                end
                for (int i = 1; i < NUM_STAGES; i++) begin
                    if (en[i]) begin
                        v[i] <= v[i-1];
                    end
                end
                if (state == RECOVER) begin
                    if (rcnt == '0) begin
                        state <= RUN;
                    end else begin
                        rcnt <= rcnt - RW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: doc/pipe_stage_ctrl.md
Name: pipe_stage_ctrl

Overview:
Valid/enable controller for a chain of NUM_STAGES plain pipeline data registers (the team's DFF primitive with per-stage load enables and clears).
- Tracks one valid bit per stage and computes per-stage load enables and clears.
- Collapses bubbles, propagates backpressure from the consumer, handles a global flush followed by a fixed recovery window.
- Sits between a producer (for example decode) and a consumer (for example rename/dispatch) in the OOO front end. The data registers themselves live outside this block.

Parameters:
NUM_STAGES, 4, number of pipeline register stages controlled (>=1)
RECOVER_CYCLES, 2, cycles in_ready is held low after a flush (0 = no recovery window)
CNT_W, 16, width of the saturating stall counter

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous, active-low reset (0 = reset)
in_valid  input  1  producer presents an entry
in_ready  output  1  controller accepts the entry this cycle
out_valid  output  1  last stage holds a valid entry for the consumer
out_ready  input  1  consumer accepts the entry this cycle
flush  input  1  discard all in-flight entries
stage_en  output  NUM_STAGES  load enable for stage i data register (stage 0 loads the producer data)
stage_clr  output  NUM_STAGES  clear for stage i data register
stage_valid  output  NUM_STAGES  registered valid bit per stage
busy  output  1  any stage valid, or recovery in progress
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset (rst=0 at posedge): v[*]=0, state=RUN, rcnt=0, stall_cnt=0.
  - While rst=0 the combinational outputs are forced: in_ready=0, out_valid=0, stage_en=0, stage_clr=all ones.
  - Reset mid-operation discards every entry with no output handshake.
- Acceptance chain (combinational):
  - acc[N-1] = !v[N-1] | out_ready
  - acc[i] = !v[i] | acc[i+1]
  - Full throughput, single-cycle hop per stage, bubbles collapse.
- Outputs:
  - stage_en[i] = acc[i] & !flush & rst
  - in_ready = acc[0] & (state==RUN) & !flush & rst
  - out_valid = v[N-1] & !flush & rst
- Valid update when stage_en[i]=1:
  - v[0] <= in_valid & in_ready
  - v[i] <= v[i-1] for i>0
  - Otherwise v[i] holds.
- Latency: an entry accepted at cycle t with no stalls presents out_valid at t+NUM_STAGES.
- Ordering: entries exit in acceptance order; none are lost or duplicated.
- Backpressure: out_ready=0 with a full chain gives in_ready=0. A single-cycle out_ready pulse frees exactly one slot, and in_ready rises in the same cycle (combinational path).
- FSM states RUN and RECOVER.
  - RUN, flush=1: stage_clr=all ones and stage_en=0 this cycle. Next cycle: v=0, state=RECOVER with rcnt=RECOVER_CYCLES-1 (or stay RUN when RECOVER_CYCLES=0).
  - RECOVER: in_ready=0; entries already in flight are none by construction. If rcnt==0, go to RUN, else decrement rcnt. This gives exactly RECOVER_CYCLES cycles of in_ready=0 after the flush cycle.
  - flush during RECOVER: stage_clr=all ones, rcnt reloads to RECOVER_CYCLES-1, stay RECOVER.
- stage_clr is otherwise 0.
- Simultaneous flush and out_ready with v[N-1]=1: no transfer; flush wins.
- Simultaneous flush and in_valid: entry not accepted.
- stall_cnt increments when out_valid=1 and out_ready=0; holds at 2^CNT_W-1; cleared only by reset.
- busy = |v | (state==RECOVER).
- stage_valid = v (registered, unaffected by flush until the next edge).

Test Plan:
- Streaming: NUM_STAGES=4, out_ready=1, in_valid=1 from cycle 0 for 8 cycles with tags 0..7 -> out_valid first at cycle 4, tags 0..7 on consecutive cycles, in_ready constantly 1.
- Backpressure: fill 4 entries, out_ready=0 for 5 cycles -> in_ready=0 once full, stall_cnt=5, stage_valid=4'b1111 held. Then out_ready=1 -> tags drain in order, one per cycle.
- Bubble collapse: accept A, idle 2 cycles, accept B, out_ready=0 -> A at stage 3, B at stage 2 after settling, stage_valid=4'b1100.
- Flush: chain full, pulse flush 1 cycle with out_ready=1 -> no output handshake that cycle, stage_clr=4'b1111, stage_valid=0 next cycle, in_ready=0 for exactly 2 cycles, then 1. Re-flush in the 1st recovery cycle -> in_ready low 2 more cycles.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds.
- Reset mid-operation: 3 valid entries, state RECOVER, drive rst=0 for one posedge -> stage_valid=0, busy=0, stall_cnt=0, in_ready=1 the cycle after rst returns to 1.
